// File: rtl/i2c_pkg.sv
// ============================================================================
// Module  : i2c_pkg
// Purpose : Shared command, response and sequencer-state encodings for the
//           I2C byte-level master sequencer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package i2c_pkg;

    typedef enum logic [2:0] {
        CMD_START    = 3'd0,
        CMD_STOP     = 3'd1,
        CMD_WRITE    = 3'd2,
        CMD_READ_ACK = 3'd3,
        CMD_READ_NAK = 3'd4
    } i2c_cmd_e;

    typedef enum logic [1:0] {
        RSP_DONE     = 2'd0,
        RSP_NAK      = 2'd1,
        RSP_ARB_LOST = 2'd2,
        RSP_ERR      = 2'd3
    } i2c_rsp_e;

    typedef enum logic [2:0] {
        OP_IDLE  = 3'd0,
        OP_START = 3'd1,
        OP_STOP  = 3'd2,
        OP_WBIT  = 3'd3,
        OP_WACK  = 3'd4,
        OP_RBIT  = 3'd5,
        OP_RACK  = 3'd6
    } i2c_op_t;

    localparam logic [1:0] Q_SETUP  = 2'd0;
    localparam logic [1:0] Q_RISE   = 2'd1;
    localparam logic [1:0] Q_SAMPLE = 2'd2;
    localparam logic [1:0] Q_FALL   = 2'd3;

    // Data/ack bits keep SCL low in the setup and fall quarters only.
    function automatic logic bit_scl_low(input logic [1:0] quarter);
        return (quarter == Q_SETUP) || (quarter == Q_FALL);
    endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_phase_timer.sv
// ============================================================================
// Module  : i2c_phase_timer
// Purpose : Divides each bus bit into four quarters of CLK_DIV cycles and
//           freezes while the slave stretches SCL.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module i2c_phase_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run_i,
    input  logic       hold_i,
    output logic [1:0] quarter_o,
    output logic       q_end_o
);

    localparam int             CW       = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    quarter_q, quarter_d;

    assign q_end_o   = run_i && !hold_i && (cnt_q == CNT_LAST);
    assign quarter_o = quarter_q;

    always_comb begin
        cnt_d     = cnt_q;
        quarter_d = quarter_q;
        if (!run_i) begin
            cnt_d     = '0;
            quarter_d = '0;
        end else if (!hold_i) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d     = '0;
                quarter_d = quarter_q + 2'd1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            quarter_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            quarter_q <= quarter_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/i2c_master_seq.sv
// ============================================================================
// Module  : i2c_master_seq
// Purpose : Command-driven I2C master: START/STOP/WRITE/READ sequencing with
//           clock stretching, arbitration-loss detection and open-drain drive.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module i2c_master_seq
    import i2c_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_code,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    output logic [1:0]            rsp_code,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  scl_oe,
    output logic                  sda_oe,
    output logic                  bus_busy
);

    localparam int            BW       = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    i2c_op_t               op_q, op_d;
    logic                  busy_q, busy_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [BW-1:0]         bitcnt_q, bitcnt_d;
    logic                  rnak_q, rnak_d;
    logic                  nak_q, nak_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [1:0]            rsp_code_q, rsp_code_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  sda_hold_q, sda_hold_d;
    logic                  ready_en_q;

    logic [1:0] quarter_w;
    logic       q_end_w;
    logic       hold_w;
    logic       cmd_ready_w;
    logic       err_w;
    logic       scl_oe_w, sda_oe_w;

    // A released SCL that still reads low means the slave is stretching.
    assign hold_w = (quarter_w == Q_RISE) && !scl_i;

    i2c_phase_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .run_i     (op_q != OP_IDLE),
        .hold_i    (hold_w),
        .quarter_o (quarter_w),
        .q_end_o   (q_end_w)
    );

    assign cmd_ready_w = ready_en_q && (op_q == OP_IDLE);
    assign cmd_ready   = cmd_ready_w;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_code    = rsp_code_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign bus_busy    = busy_q;
    assign scl_oe      = scl_oe_w;
    assign sda_oe      = sda_oe_w;

    always_comb begin
        scl_oe_w = 1'b0;
        sda_oe_w = 1'b0;
        case (op_q)
            OP_IDLE: begin
                scl_oe_w = busy_q;
                sda_oe_w = busy_q && sda_hold_q;
            end
            OP_START: begin
                scl_oe_w = (quarter_w == Q_SETUP) ? busy_q : (quarter_w == Q_FALL);
                sda_oe_w = quarter_w[1];
            end
            OP_STOP: begin
                scl_oe_w = (quarter_w == Q_SETUP);
                sda_oe_w = !quarter_w[1];
            end
            OP_WBIT: begin
                scl_oe_w = bit_scl_low(quarter_w);
                sda_oe_w = !shreg_q[DATA_WIDTH-1];
            end
            OP_RACK: begin
                scl_oe_w = bit_scl_low(quarter_w);
                sda_oe_w = !rnak_q;
            end
            default: begin
                scl_oe_w = bit_scl_low(quarter_w);
                sda_oe_w = 1'b0;
            end
        endcase
    end

    always_comb begin
        op_d        = op_q;
        busy_d      = busy_q;
        shreg_d     = shreg_q;
        bitcnt_d    = bitcnt_q;
        rnak_d      = rnak_q;
        nak_d       = nak_q;
        rsp_valid_d = 1'b0;
        rsp_code_d  = rsp_code_q;
        rsp_rdata_d = rsp_rdata_q;
        sda_hold_d  = (op_q == OP_IDLE) ? sda_hold_q : sda_oe_w;
        err_w       = 1'b0;
        case (op_q)
            OP_IDLE: begin
                if (cmd_valid && cmd_ready_w) begin
                    bitcnt_d = '0;
                    case (cmd_code)
                        CMD_START: op_d = OP_START;
                        CMD_STOP: begin
                            if (busy_q) op_d = OP_STOP;
                            else        err_w = 1'b1;
                        end
                        CMD_WRITE: begin
                            if (busy_q) begin
                                op_d    = OP_WBIT;
                                shreg_d = cmd_wdata;
                            end else begin
                                err_w = 1'b1;
                            end
                        end
                        CMD_READ_ACK, CMD_READ_NAK: begin
                            if (busy_q) begin
                                op_d   = OP_RBIT;
                                rnak_d = (cmd_code == CMD_READ_NAK);
                            end else begin
                                err_w = 1'b1;
                            end
                        end
                        default: err_w = 1'b1;
                    endcase
                    if (err_w) begin
                        rsp_valid_d = 1'b1;
                        rsp_code_d  = RSP_ERR;
                    end
                end
            end
            OP_START, OP_STOP: begin
                if (q_end_w && quarter_w == Q_FALL) begin
                    op_d        = OP_IDLE;
                    busy_d      = (op_q == OP_START);
                    rsp_valid_d = 1'b1;
                    rsp_code_d  = RSP_DONE;
                end
            end
            OP_WBIT: begin
                if (q_end_w && quarter_w == Q_SAMPLE && shreg_q[DATA_WIDTH-1] && !sda_i) begin
                    op_d        = OP_IDLE;
                    busy_d      = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_code_d  = RSP_ARB_LOST;
                end else if (q_end_w && quarter_w == Q_FALL) begin
                    if (bitcnt_q == LAST_BIT) begin
                        op_d = OP_WACK;
                    end else begin
                        bitcnt_d = bitcnt_q + 1'b1;
                        shreg_d  = {shreg_q[DATA_WIDTH-2:0], 1'b0};
                    end
                end
            end
            OP_WACK: begin
                if (q_end_w && quarter_w == Q_SAMPLE) begin
                    nak_d = sda_i;
                end else if (q_end_w && quarter_w == Q_FALL) begin
                    op_d        = OP_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_code_d  = nak_q ? RSP_NAK : RSP_DONE;
                end
            end
            OP_RBIT: begin
                if (q_end_w && quarter_w == Q_SAMPLE) begin
                    shreg_d = {shreg_q[DATA_WIDTH-2:0], sda_i};
                end else if (q_end_w && quarter_w == Q_FALL) begin
                    if (bitcnt_q == LAST_BIT) op_d = OP_RACK;
                    else                      bitcnt_d = bitcnt_q + 1'b1;
                end
            end
            OP_RACK: begin
                if (q_end_w && quarter_w == Q_FALL) begin
                    op_d        = OP_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_code_d  = RSP_DONE;
                    rsp_rdata_d = shreg_q;
                end
            end
            default: op_d = OP_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= OP_IDLE;
            busy_q      <= 1'b0;
            shreg_q     <= '0;
            bitcnt_q    <= '0;
            rnak_q      <= 1'b0;
            nak_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_code_q  <= RSP_DONE;
            rsp_rdata_q <= '0;
            sda_hold_q  <= 1'b0;
            ready_en_q  <= 1'b0;
        end else begin
            op_q        <= op_d;
            busy_q      <= busy_d;
            shreg_q     <= shreg_d;
            bitcnt_q    <= bitcnt_d;
            rnak_q      <= rnak_d;
            nak_q       <= nak_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_code_q  <= rsp_code_d;
            rsp_rdata_q <= rsp_rdata_d;
            sda_hold_q  <= sda_hold_d;
            ready_en_q  <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_i2c_master_seq.sv
// ============================================================================
// Module  : tb_i2c_master_seq
// Purpose : Self-checking bench with a behavioural slave and a response
//           scoreboard for i2c_master_seq (CLK_DIV = 4).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_i2c_master_seq;

    localparam int CD = 4;
    localparam logic [2:0] C_START = 3'd0, C_STOP = 3'd1, C_WRITE = 3'd2,
                           C_RACK  = 3'd3, C_RNAK = 3'd4, C_BAD  = 3'd7;
    localparam logic [1:0] E_DONE = 2'd0, E_NAK = 2'd1, E_ARB = 2'd2, E_ERR = 2'd3;
    localparam int LAT_SS = 4 * CD + 1;
    localparam int LAT_BY = 36 * CD + 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [2:0] cmd_code = 3'd0;
    logic [7:0] cmd_wdata = 8'd0;
    logic       cmd_ready, rsp_valid;
    logic [1:0] rsp_code;
    logic [7:0] rsp_rdata;
    logic       scl_i, sda_i, scl_oe, sda_oe, bus_busy;

    i2c_master_seq #(.DATA_WIDTH(8), .CLK_DIV(CD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_code  (cmd_code),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_code  (rsp_code),
        .rsp_rdata (rsp_rdata),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .scl_oe    (scl_oe),
        .sda_oe    (sda_oe),
        .bus_busy  (bus_busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- behavioural slave / competing master ----------------
    int         bitn = -1;
    int         st_cnt = 0;
    int         s_arb_bit = -1;
    logic       prev_scl = 1'b1, prev_sda = 1'b1;
    logic [7:0] rx = 8'd0;
    logic       ack_seen = 1'b1;
    logic       s_ack = 1'b0, s_read = 1'b0, s_stretch = 1'b0;
    logic [7:0] s_rdata = 8'd0;
    logic       slave_pull, stretch_hold;
    logic [2:0] ridx;

    always_comb begin
        slave_pull   = 1'b0;
        ridx         = 3'(7 - bitn);
        stretch_hold = s_stretch && (bitn == 0) && (st_cnt < 20) && !scl_oe;
        if (!s_read && s_ack && bitn == 8)              slave_pull = 1'b1;
        if (s_read && bitn >= 0 && bitn < 8)            slave_pull = !s_rdata[ridx];
        if (s_arb_bit >= 0 && bitn == s_arb_bit)        slave_pull = 1'b1;
    end

    assign scl_i = !scl_oe && !stretch_hold;
    assign sda_i = !sda_oe && !slave_pull;

    always @(posedge clk) begin
        prev_scl <= scl_i;
        prev_sda <= sda_i;
        if (!s_stretch)        st_cnt <= 0;
        else if (stretch_hold) st_cnt <= st_cnt + 1;
        if (prev_scl && scl_i && prev_sda && !sda_i) bitn <= -1;
        else if (prev_scl && !scl_i)                 bitn <= (bitn == 8) ? 0 : bitn + 1;
        if (!prev_scl && scl_i) begin
            if (bitn >= 0 && bitn < 8) rx <= {rx[6:0], sda_i};
            if (bitn == 8)             ack_seen <= sda_i;
        end
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [1:0] code;
        logic [7:0] rd;
        bit         chk_rd;
        int         lat;
        int         acc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    // Latency is counted up to the edge that samples rsp_valid high.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (sb.size() == 0) begin
                check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_code", 32'(rsp_code), 32'(mon_e.code));
                if (mon_e.lat > 0) check("rsp_latency", 32'(cyc + 1 - mon_e.acc), 32'(mon_e.lat));
                if (mon_e.chk_rd)  check("rsp_rdata", 32'(rsp_rdata), 32'(mon_e.rd));
            end
        end
    end

    task automatic wait_rsp();
        int n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("rsp_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic [2:0] code, input logic [7:0] wd, output int acc, output bit ok);
        int n = 0;
        @(negedge clk);
        cmd_code  = code;
        cmd_wdata = wd;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = cmd_ready;
        if (!ok) begin
            check("cmd_ready_timeout", 32'd0, 32'd1);
            cmd_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
            acc = cyc;
        end
    endtask

    task automatic send(input logic [2:0] code, input logic [7:0] wd, input logic [1:0] ecode,
                        input logic [7:0] erd, input bit chk_rd, input int elat);
        exp_t e;
        int   acc;
        bit   ok;
        drive(code, wd, acc, ok);
        if (ok) begin
            e.code = ecode; e.rd = erd; e.chk_rd = chk_rd; e.lat = elat; e.acc = acc;
            sb.push_back(e);
            wait_rsp();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        int   acc;
        bit   ok;
        logic act;
        int   scl_hi;

        repeat (3) @(negedge clk);
        check("rst_scl_oe",    32'(scl_oe),    32'd0);
        check("rst_sda_oe",    32'(sda_oe),    32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_code",  32'(rsp_code),  32'(E_DONE));
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_bus_busy",  32'(bus_busy),  32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_rst", 32'(cmd_ready), 32'd1);

        // Commands that need an owned bus are refused without touching the lines.
        send(C_WRITE, 8'h55, E_ERR, 8'h00, 1'b0, 1);
        act = 1'b0;
        repeat (10) begin @(negedge clk); act = act | scl_oe | sda_oe; end
        check("err_line_activity", 32'(act), 32'd0);
        send(C_STOP, 8'h00, E_ERR, 8'h00, 1'b0, 1);
        send(C_BAD,  8'h00, E_ERR, 8'h00, 1'b0, 1);

        // START then WRITE 0xA4 acknowledged.
        send(C_START, 8'h00, E_DONE, 8'h00, 1'b0, LAT_SS);
        check("busy_after_start", 32'(bus_busy), 32'd1);
        check("idle_scl_held",    32'(scl_oe),   32'd1);
        s_ack = 1'b1;
        send(C_WRITE, 8'hA4, E_DONE, 8'h00, 1'b0, LAT_BY);
        check("write_bits_a4", 32'(rx), 32'hA4);
        check("busy_after_write", 32'(bus_busy), 32'd1);

        // Unacknowledged write.
        s_ack = 1'b0;
        send(C_WRITE, 8'h3B, E_NAK, 8'h00, 1'b0, LAT_BY);
        check("write_bits_3b", 32'(rx), 32'h3B);

        // Reads: ACK then NAK.
        s_read = 1'b1; s_rdata = 8'h81;
        send(C_RACK, 8'h00, E_DONE, 8'h81, 1'b1, LAT_BY);
        check("master_ack_bit", 32'(ack_seen), 32'd0);
        s_rdata = 8'h3C;
        send(C_RNAK, 8'h00, E_DONE, 8'h3C, 1'b1, LAT_BY);
        check("master_nak_bit", 32'(ack_seen), 32'd1);
        s_read = 1'b0;

        send(C_STOP, 8'h00, E_DONE, 8'h00, 1'b0, LAT_SS);
        check("busy_after_stop", 32'(bus_busy),  32'd0);
        check("stop_scl_rel",    32'(scl_oe),    32'd0);
        check("stop_sda_rel",    32'(sda_oe),    32'd0);
        check("rdata_held",      32'(rsp_rdata), 32'h3C);

        // Clock stretching of 20 cycles in the first bit of a write.
        send(C_START, 8'h00, E_DONE, 8'h00, 1'b0, LAT_SS);
        s_ack = 1'b1; s_stretch = 1'b1;
        send(C_WRITE, 8'hA4, E_DONE, 8'h00, 1'b0, LAT_BY + 20);
        check("stretch_cycles", 32'(st_cnt), 32'd20);
        s_stretch = 1'b0; s_ack = 1'b0;

        // Arbitration lost on bit index 5 of 0xFF.
        s_arb_bit = 2;
        send(C_WRITE, 8'hFF, E_ARB, 8'h00, 1'b0, 0);
        check("arb_busy", 32'(bus_busy), 32'd0);
        check("arb_scl",  32'(scl_oe),   32'd0);
        check("arb_sda",  32'(sda_oe),   32'd0);
        scl_hi = 0;
        repeat (40) begin @(negedge clk); scl_hi += int'(scl_oe); end
        check("arb_no_scl_pulses", 32'(scl_hi), 32'd0);
        s_arb_bit = -1;

        // Reset in the middle of a write: lines drop at once, no response.
        send(C_START, 8'h00, E_DONE, 8'h00, 1'b0, LAT_SS);
        drive(C_WRITE, 8'h00, acc, ok);
        repeat (50) @(negedge clk);
        check("pre_rst_scl", 32'(scl_oe), 32'd1);
        check("pre_rst_sda", 32'(sda_oe), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_scl",  32'(scl_oe),   32'd0);
        check("midrst_sda",  32'(sda_oe),   32'd0);
        check("midrst_busy", 32'(bus_busy), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("midrst_ready", 32'(cmd_ready), 32'd1);
        repeat (200) @(negedge clk);
        check("midrst_no_rsp", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/i2c_master_seq.md
I2C_MASTER_SEQ -- requirements
Module: i2c_master_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, byte width on the bus.
REQ-002 SHALL have parameter CLK_DIV, default 4, clk cycles per SCL quarter-period (legal >= 2).
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_ready  output  1  command accepted when both cmd_valid and cmd_ready are high.
REQ-007 SHALL have port cmd_code  input  3  START, STOP, WRITE, READ_ACK, READ_NAK; other codes illegal.
REQ-008 SHALL have port cmd_wdata  input  DATA_WIDTH  byte for WRITE.
REQ-009 SHALL have port rsp_valid  output  1  one-cycle completion pulse.
REQ-010 SHALL have port rsp_code  output  2  DONE, NAK, ARB_LOST, ERR.
REQ-011 SHALL have port rsp_rdata  output  DATA_WIDTH  byte captured by READ_*; holds its value until the next read completes.
REQ-012 SHALL have ports scl_i and sda_i  input  1 each  sampled bus lines.
REQ-013 SHALL have ports scl_oe and sda_oe  output  1 each  1 = pull line low, 0 = release (open-drain).
REQ-014 SHALL have port bus_busy  output  1  high from START completion until STOP completion or arbitration loss.

Function
REQ-015 SHALL use FSM states IDLE, START, STOP, WBIT, WACK, RBIT, RACK; each bus bit spans quarters q0..q3 of CLK_DIV cycles each.
REQ-016 SHALL assert cmd_ready only in IDLE, and SHALL accept a command in the same cycle as a rsp_valid pulse.
REQ-017 START phases: q0 release sda; q1 release scl; q2 pull sda; q3 pull scl; the same sequence serves a repeated START while bus_busy.
REQ-018 STOP phases: q0 pull sda; q1 release scl; q2 release sda; q3 hold; then clear bus_busy.
REQ-019 WBIT phases, MSB first: q0 sda_oe = ~bit; q1 release scl; q2 sample sda_i; q3 pull scl.
REQ-020 WACK SHALL release sda and sample sda_i at q2: 0 gives DONE, 1 gives NAK.
REQ-021 RBIT SHALL release sda and shift sda_i in at q2, MSB first.
REQ-022 RACK SHALL pull sda for READ_ACK and release sda for READ_NAK, then respond DONE.
REQ-023 In q1 the quarter counter SHALL hold until scl_i reads 1 (clock stretching); stretch cycles add one-for-one to latency.
REQ-024 Arbitration loss: if a WBIT has sda released and sda_i=0 at q2, the block SHALL release both lines next cycle, clear bus_busy, respond ARB_LOST and return to IDLE.
REQ-025 Latency from accept to rsp_valid, without stretching: START/STOP 4*CLK_DIV+1 cycles; WRITE/READ 36*CLK_DIV+1 cycles.
REQ-026 ERR conditions: WRITE, READ_* or STOP with bus_busy=0, or an illegal code.
REQ-027 On ERR the block SHALL respond ERR on the cycle after accept with no line activity.
REQ-028 Outside an operation, with bus_busy=1, the block SHALL hold scl pulled low and sda unchanged; with bus_busy=0, both lines SHALL be released.

Reset
REQ-029 While rst_n=0: scl_oe=0, sda_oe=0, cmd_ready=0, rsp_valid=0, rsp_code=DONE, rsp_rdata=0, bus_busy=0, state IDLE, counters 0.
REQ-030 Reset asserted mid-operation SHALL release both lines immediately with no response for the aborted command.
REQ-031 cmd_ready SHALL rise on the first clk edge after rst_n deasserts.

Structure
REQ-032 Command and response enums SHALL live in shared package i2c_pkg, beside i2c_op_t.
REQ-033 Quarter/stretch timing SHALL be sub-module i2c_phase_timer (outputs quarter index and end-of-quarter strobe; input stretch hold).

Verification (CLK_DIV=4)
REQ-034 START then WRITE 0xA4 with slave ACK: sda bits 1,0,1,0,0,1,0,0; rsp DONE 145 cycles after WRITE accept; bus_busy=1.
REQ-035 READ_NAK with slave driving 0x3C: rsp DONE, rsp_rdata=0x3C, sda_oe=0 during bit 9; then STOP gives bus_busy=0.
REQ-036 WRITE 0x55 at bus_busy=0: rsp ERR on the next cycle, scl_oe and sda_oe remain 0.
REQ-037 WRITE 0xFF with sda_i forced 0 in bit index 5 (third bit): rsp ARB_LOST, both oe=0, bus_busy=0, no further scl pulses.
REQ-038 scl_i held low 20 cycles in q1 of bit 7 during WRITE: rsp arrives exactly 20 cycles later than in REQ-034.
REQ-039 rst_n pulsed low mid-WRITE: scl_oe=sda_oe=0 within the same cycle, no rsp_valid, cmd_ready=1 one cycle after release.
